// File: rtl/layer_compositor.sv
// layer_compositor
// ----------------
// N-layer pixel compositor for the pixel clock domain. Each strobed pixel picks
// the highest-priority opaque layer (layer 0 wins). The candidate set is gated
// by a per-game-state enable mask that software can rewrite. Stage 2 applies a
// night-palette remap in REMAP_STATE. It also inverts the pixel while the flash
// effect started on entry to FLASH_STATE is running.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   pix_en       pixel strobe, inputs valid this cycle
//   frame_start  one-cycle pulse on the first pixel of a frame
//   state        current game state (sampled only at a strobed frame_start)
//   layer_pix    packed layer pixels, layer i at [i*PIX_W +: PIX_W]
//   layer_flag   per-layer opacity for this pixel
//   bg_pix       background pixel, used when no enabled layer is opaque
//   cfg_we       mask-table write strobe
//   cfg_state    mask-table entry to write
//   cfg_mask     new layer-enable mask
//   pix_out      composited pixel (holds while pix_valid is low)
//   pix_valid    pix_out carries a new pixel, 2 clocks after its pix_en
//   flashing     flash effect active
module layer_compositor #(
  parameter int                 PIX_W        = 8,
  parameter int                 NUM_LAYERS   = 6,
  parameter int                 STATE_W      = 3,
  parameter logic [STATE_W-1:0] REMAP_STATE  = 3'b100,
  parameter logic [STATE_W-1:0] FLASH_STATE  = 3'b101,
  parameter int                 FLASH_FRAMES = 8,
  parameter logic [PIX_W-1:0]   REMAP_IN0    = 8'h1F,
  parameter logic [PIX_W-1:0]   REMAP_OUT0   = 8'h4F,
  parameter logic [PIX_W-1:0]   REMAP_IN1    = 8'hFF,
  parameter logic [PIX_W-1:0]   REMAP_OUT1   = 8'h1E,
  parameter logic [PIX_W-1:0]   REMAP_IN2    = 8'h1D,
  parameter logic [PIX_W-1:0]   REMAP_OUT2   = 8'hBE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pix_en,
  input  logic                        frame_start,
  input  logic [STATE_W-1:0]          state,
  input  logic [NUM_LAYERS*PIX_W-1:0] layer_pix,
  input  logic [NUM_LAYERS-1:0]       layer_flag,
  input  logic [PIX_W-1:0]            bg_pix,
  input  logic                        cfg_we,
  input  logic [STATE_W-1:0]          cfg_state,
  input  logic [NUM_LAYERS-1:0]       cfg_mask,
  output logic [PIX_W-1:0]            pix_out,
  output logic                        pix_valid,
  output logic                        flashing
);

  localparam int NUM_STATES = 1 << STATE_W;
  localparam int CNT_W      = 8;
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_FRAMES);

  // A frame boundary only counts when it arrives together with a pixel strobe.
  logic frame_latch;
  assign frame_latch = frame_start & pix_en;

  // ---------------------------------------------------------------------------
  // Layer-enable mask table, one entry per game state.
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] mask_reg [NUM_STATES];

  generate
    for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_mask
      localparam logic [STATE_W-1:0] ENTRY = STATE_W'(gi);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mask_reg[gi] <= '1;
        end else if (cfg_we && (cfg_state == ENTRY)) begin
          mask_reg[gi] <= cfg_mask;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Frame-latched game state and flash counter.
  // frame_state_reg still holds the previous frame's state at the latch edge,
  // so comparing it with the incoming state detects entry into FLASH_STATE.
  // ---------------------------------------------------------------------------
  logic [STATE_W-1:0] frame_state_reg;
  logic [CNT_W-1:0]   flash_cnt_reg, flash_cnt_next;
  logic               flashing_reg, flashing_next;

  always_comb begin
    flash_cnt_next = flash_cnt_reg;
    flashing_next  = flashing_reg;
    if (frame_latch) begin
      if ((state == FLASH_STATE) && (frame_state_reg != FLASH_STATE)) begin
        flash_cnt_next = FLASH_LOAD;
        flashing_next  = 1'b1;
      end else if (state != FLASH_STATE) begin
        // Leaving (or never being in) the flash state cancels any flash.
        flash_cnt_next = '0;
        flashing_next  = 1'b0;
      end else if (flash_cnt_reg != '0) begin
        flash_cnt_next = flash_cnt_reg - 1'b1;
        flashing_next  = (flash_cnt_reg != CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_state_reg <= '0;
      flash_cnt_reg   <= '0;
      flashing_reg    <= 1'b0;
    end else begin
      if (frame_latch) begin
        frame_state_reg <= state;
      end
      flash_cnt_reg <= flash_cnt_next;
      flashing_reg  <= flashing_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: priority select among enabled, opaque layers.
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] eff_flag;
  logic [PIX_W-1:0]      sel_pix;
  logic [PIX_W-1:0]      s1_pix_reg;
  logic                  s1_valid_reg;

  assign eff_flag = layer_flag & mask_reg[frame_state_reg];

  // Walk from lowest to highest priority so the last hit (lowest index) wins.
  always_comb begin
    sel_pix = bg_pix;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff_flag[i]) begin
        sel_pix = layer_pix[i*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_pix_reg   <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= pix_en;
      if (pix_en) begin
        s1_pix_reg <= sel_pix;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: palette remap, then flash inversion using the live flash flag.
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] remap_pix;
  logic [PIX_W-1:0] final_pix;
  logic [PIX_W-1:0] pix_out_reg;
  logic             pix_valid_reg;

  always_comb begin
    remap_pix = s1_pix_reg;
    if (frame_state_reg == REMAP_STATE) begin
      if (s1_pix_reg == REMAP_IN0) begin
        remap_pix = REMAP_OUT0;
      end else if (s1_pix_reg == REMAP_IN1) begin
        remap_pix = REMAP_OUT1;
      end else if (s1_pix_reg == REMAP_IN2) begin
        remap_pix = REMAP_OUT2;
      end
    end
  end

  assign final_pix = flashing_reg ? ~remap_pix : remap_pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out_reg   <= '0;
      pix_valid_reg <= 1'b0;
    end else begin
      pix_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        pix_out_reg <= final_pix;
      end
    end
  end

  assign pix_out   = pix_out_reg;
  assign pix_valid = pix_valid_reg;
  assign flashing  = flashing_reg;

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
Parametrised N-layer pixel compositor; successor to the fixed six-source display mux. Selects the highest-priority active layer per pixel, gated by a per-game-state layer-enable mask table that software can rewrite. Applies a night-palette remap in one state and a frame-counted flash effect on entry to another. Sits between the sprite/background generators and the VGA output register, inside the pixel clock domain.

Parameters:
PIX_W, 8, pixel colour width (RGB332 at default)
NUM_LAYERS, 6, number of overlay layers; layer 0 is highest priority
STATE_W, 3, game-state width; mask table holds 2**STATE_W entries
REMAP_STATE, 3'b100, state in which the palette remap applies
FLASH_STATE, 3'b101, state whose entry triggers the flash effect
FLASH_FRAMES, 8, number of frames the flash lasts (1..255)
REMAP_IN0/OUT0, 8'h1F/8'h4F, remap pair 0
REMAP_IN1/OUT1, 8'hFF/8'h1E, remap pair 1
REMAP_IN2/OUT2, 8'h1D/8'hBE, remap pair 2

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel strobe; inputs valid this cycle
frame_start  in  1  one-cycle pulse at the first pixel of a frame
state  in  STATE_W  current game state from the FSM
layer_pix  in  NUM_LAYERS*PIX_W  packed layer pixels; layer i at [i*PIX_W +: PIX_W]
layer_flag  in  NUM_LAYERS  layer i opaque at this pixel
bg_pix  in  PIX_W  background pixel (lowest priority)
cfg_we  in  1  mask-table write strobe
cfg_state  in  STATE_W  mask-table entry to write
cfg_mask  in  NUM_LAYERS  new enable mask
pix_out  out  PIX_W  composited pixel
pix_valid  out  1  pix_out valid
flashing  out  1  flash effect active

Behaviour:
- Reset (rst_n=0, asynchronous): pix_out=0, pix_valid=0, flashing=0, every mask entry = all ones, frame_state=0, prev_frame_state=0, flash counter=0.
- Frame-latched state: frame_state captures `state` only in a cycle where frame_start=1 and pix_en=1. All selection uses frame_state, so no mid-frame tearing. A frame_start without pix_en is ignored.
- Mask table: when cfg_we=1, mask[cfg_state] <= cfg_mask at the clock edge. The new value is used from the next cycle on. A write to the entry for the current frame_state takes effect mid-frame; this is permitted.
- Stage 1 (registered on pix_en):
  - eff = layer_flag & mask[frame_state].
  - sel = the lowest index i with eff[i]=1, giving layer_pix[i]; if eff=0, sel = bg_pix.
  - s1_valid <= pix_en.
- Stage 2 (registered):
  - If frame_state==REMAP_STATE, replace the matching REMAP_INk with REMAP_OUTk; pair 0 is checked first, then 1, then 2.
  - If flashing=1, invert all bits of the result after the remap.
  - pix_valid <= s1_valid.
- Latency: exactly 2 clocks from a pix_en cycle to the matching pix_valid.
- Gaps: pix_en=0 inserts bubbles; pix_out holds its last value while pix_valid=0.
- Flash:
  - When frame_state is updated to FLASH_STATE from a different prev_frame_state, load counter=FLASH_FRAMES and set flashing=1 starting the next cycle.
  - Each later latched frame_start decrements the counter; flashing clears when it reaches 0.
  - The same state latched again does not retrigger.
  - Leaving FLASH_STATE mid-flash clears the counter and flashing at that frame_start.
  - flashing is applied at stage 2 using its current value; it is not delayed to match pipeline position.
- Simultaneous cfg_we and frame_start: both take effect. The selection in that cycle uses the old mask.
- Reset mid-frame: the pipeline flushes immediately; pix_valid=0 until 2 cycles after the first pix_en after release.

Test Plan:
- Reset, then pix_en every cycle with layer_flag=6'b000110, layer1=8'hAA, layer2=8'h55, state=0 latched -> pix_out=8'hAA, pix_valid high 2 cycles after the first pix_en.
- Write cfg_state=0, cfg_mask=6'b111101, same pixel -> pix_out=8'h55 from the 3rd cycle after the write; layer_flag=0 -> pix_out=bg_pix.
- Latch state=REMAP_STATE at frame_start, bg_pix=8'h1F/8'hFF/8'h1D/8'h20 with no flags -> 8'h4F/8'h1E/8'hBE/8'h20. Same inputs with state=0 pass through unchanged.
- Change `state` mid-frame (no frame_start) -> output selection unchanged until the next frame_start pulse.
- Latch FLASH_STATE from state 0 with FLASH_FRAMES=8, bg_pix=8'h0F -> flashing=1 and pix_out=8'hF0 for 8 frames, then 8'h0F. Re-latching FLASH_STATE does not retrigger; switching to state 0 after 3 frames clears flashing at that frame_start.
- Assert rst_n=0 mid-stream with cfg mask modified -> outputs 0 at once asynchronously, masks back to all ones, pix_valid returns 2 cycles after pix_en post-release.
